// File: rtl/da_pkg.sv
// Shared types and constants for the distributed-arithmetic bit-plane front end.
// Holds the FSM encoding and the coefficient sign-extension helper.
package da_pkg;

  localparam int SW     = 8;
  localparam int NPLANE = 8;
  localparam int KW     = 3;
  localparam int MAXTAP = 8;
  localparam int CW_DEF = 20;
  localparam int OW_DEF = 28;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Sign-extends the low cw bits of c to 64 bits; callers cast to OW.
  function automatic logic signed [63:0] sext_cw_to_ow(
    input logic [63:0] c,
    input int          cw
  );
    logic signed [63:0] t;
    t = signed'(c << (64 - cw));
    return t >>> (64 - cw);
  endfunction

endpackage

// File: rtl/da_plane_sum.sv
// Combinational plane sum: adds the sign-extended coefficient of every tap
// whose selected sample bit is set, using a fixed three-level adder tree.
module da_plane_sum
  import da_pkg::*;
#(
  parameter int NTAP = 4,
  parameter int CW   = CW_DEF,
  parameter int OW   = OW_DEF
) (
  input  logic [NTAP-1:0]      i_bits,
  input  logic [NTAP*CW-1:0]   i_coef,
  output logic signed [OW-1:0] o_sum
);

  logic signed [OW-1:0] w_leaf [MAXTAP];
  logic signed [OW-1:0] w_l1   [MAXTAP/2];
  logic signed [OW-1:0] w_l2   [MAXTAP/4];

  for (genvar j = 0; j < MAXTAP; j++) begin : g_leaf
    if (j < NTAP) begin : g_tap
      assign w_leaf[j] = i_bits[j]
        ? OW'(sext_cw_to_ow(64'(i_coef[j*CW +: CW]), CW))
        : '0;
    end else begin : g_pad
      assign w_leaf[j] = '0;
    end
  end

  for (genvar i = 0; i < MAXTAP/2; i++) begin : g_l1
    assign w_l1[i] = w_leaf[2*i] + w_leaf[2*i+1];
  end

  for (genvar i = 0; i < MAXTAP/4; i++) begin : g_l2
    assign w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
  end

  assign o_sum = w_l2[0] + w_l2[1];

endmodule

// File: rtl/da_bitplane_gen.sv
// Bit-plane generator: latches one frame, computes Y0..Y7 one plane per
// clock, then holds them until the downstream combiner accepts.
module da_bitplane_gen
  import da_pkg::*;
#(
  parameter int NTAP = 4,
  parameter int CW   = CW_DEF,
  parameter int OW   = OW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NTAP*SW-1:0]   x,
  input  logic [NTAP*CW-1:0]   coef,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] Y0,
  output logic signed [OW-1:0] Y1,
  output logic signed [OW-1:0] Y2,
  output logic signed [OW-1:0] Y3,
  output logic signed [OW-1:0] Y4,
  output logic signed [OW-1:0] Y5,
  output logic signed [OW-1:0] Y6,
  output logic signed [OW-1:0] Y7
);

  if (NTAP < 1 || NTAP > MAXTAP) begin : g_bad_ntap
    $error("da_bitplane_gen: NTAP must be 1..8");
  end
  if (OW < CW + $clog2(NTAP)) begin : g_bad_ow
    $error("da_bitplane_gen: OW too narrow for CW and NTAP");
  end
  if (CW < 2 || CW > 64 || OW > 64) begin : g_bad_w
    $error("da_bitplane_gen: CW/OW out of range");
  end

  state_t               r_state;
  logic [KW-1:0]        r_k;
  logic [NTAP*SW-1:0]   r_x;
  logic [NTAP*CW-1:0]   r_coef;
  logic signed [OW-1:0] r_y [NPLANE];
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic [NTAP-1:0]      w_bits;
  logic signed [OW-1:0] w_sum;

  // The plane counter picks bit k from every latched sample.
  for (genvar j = 0; j < NTAP; j++) begin : g_bit
    logic [SW-1:0] w_s;
    assign w_s       = r_x[j*SW +: SW];
    assign w_bits[j] = w_s[r_k];
  end

  da_plane_sum #(
    .NTAP (NTAP),
    .CW   (CW),
    .OW   (OW)
  ) u_sum (
    .i_bits (w_bits),
    .i_coef (r_coef),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_x         <= '0;
      r_coef      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NPLANE; i++) begin
        r_y[i] <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x        <= x;
            r_coef     <= coef;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_y[r_k] <= w_sum;
          r_k      <= r_k + 1'b1;
          if (r_k == KW'(NPLANE - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  assign Y0 = r_y[0];
  assign Y1 = r_y[1];
  assign Y2 = r_y[2];
  assign Y3 = r_y[3];
  assign Y4 = r_y[4];
  assign Y5 = r_y[5];
  assign Y6 = r_y[6];
  assign Y7 = r_y[7];

endmodule

// File: tb/tb_da_bitplane_gen.sv
// Directed bench for da_bitplane_gen (NTAP=4, CW=20, OW=28) with
// hand-computed plane sums.
module tb_da_bitplane_gen;

  localparam int NTAP = 4;
  localparam int CW   = 20;
  localparam int OW   = 28;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NTAP*8-1:0] x = '0;
  logic [NTAP*CW-1:0] coef = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OW-1:0]     Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic [8*OW-1:0]   yall;

  int n_chk  = 0;
  int n_fail = 0;

  assign yall = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  always #5 clk = ~clk;

  da_bitplane_gen #(
    .NTAP (NTAP),
    .CW   (CW),
    .OW   (OW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .coef      (coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y0        (Y0),
    .Y1        (Y1),
    .Y2        (Y2),
    .Y3        (Y3),
    .Y4        (Y4),
    .Y5        (Y5),
    .Y6        (Y6),
    .Y7        (Y7)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_ys(input string tag, input logic [8*OW-1:0] e);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_Y%0d", tag, i),
            64'(yall[i*OW +: OW]), 64'(e[i*OW +: OW]));
    end
  endtask

  // Drive a frame and return just after its accept edge.
  task automatic accept(input logic [NTAP*8-1:0] xv,
                        input logic [NTAP*CW-1:0] cv);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    x        = xv;
    coef     = cv;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd8);
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 64'(out_valid), 64'd0);
    check({tag, "_ir_set"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_frame(input string tag,
                           input logic [NTAP*8-1:0] xv,
                           input logic [NTAP*CW-1:0] cv,
                           input logic [8*OW-1:0] e);
    accept(xv, cv);
    wait_done(tag);
    check_ys(tag, e);
    release_out(tag);
  endtask

  localparam logic [NTAP*8-1:0]  X_ONE  = 32'h0000_00FF;
  localparam logic [NTAP*CW-1:0] C_ONE  = {20'd0, 20'd0, 20'd0, 20'd5};
  localparam logic [8*OW-1:0]    E_ONE  = {8{28'd5}};
  localparam logic [NTAP*8-1:0]  X_MIX  = 32'h0000_0503;
  localparam logic [NTAP*CW-1:0] C_MIX  = {20'd0, 20'd0, 20'hFFFFC, 20'd10};
  localparam logic [8*OW-1:0]    E_MIX  =
    {{5{28'd0}}, 28'hFFFFFFC, 28'd10, 28'd6};
  localparam logic [NTAP*8-1:0]  X_B    = 32'h0000_00F0;
  localparam logic [NTAP*CW-1:0] C_B    = {20'd0, 20'd0, 20'd0, 20'd7};
  localparam logic [8*OW-1:0]    E_B    = {{4{28'd7}}, {4{28'd0}}};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check_ys("rst", '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_first_ready", 64'(in_ready), 64'd1);

    run_frame("one", X_ONE, C_ONE, E_ONE);
    run_frame("msb", 32'h0000_0080, {20'd0, 20'd0, 20'd0, 20'hFFFFD},
              {28'hFFFFFFD, {7{28'd0}}});
    run_frame("mix", X_MIX, C_MIX, E_MIX);
    run_frame("ext", 32'hFFFF_FFFF, {4{20'h80000}}, {8{28'hFE00000}});
    run_frame("zero", 32'h0, {20'd1, 20'd2, 20'd3, 20'd4}, '0);

    // Backpressure with a second frame waiting on in_valid.
    accept(X_MIX, C_MIX);
    wait_done("bp_a");
    @(negedge clk);
    in_valid = 1'b1;
    x        = X_B;
    coef     = C_B;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_ov_%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_ir_%0d", c), 64'(in_ready), 64'd0);
      check_ys($sformatf("bp_hold%0d", c), E_MIX);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle_ov", 64'(out_valid), 64'd0);
    check("bp_idle_ir", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_b_taken", 64'(in_ready), 64'd0);
    wait_done("bp_b");
    check_ys("bp_b", E_B);
    release_out("bp_b");

    // Asynchronous reset while plane 3 is being computed.
    accept(X_ONE, C_ONE);
    repeat (3) @(posedge clk);
    #1;
    check("mid_y0", 64'(Y0), 64'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ov", 64'(out_valid), 64'd0);
    check("mid_rst_ir", 64'(in_ready), 64'd1);
    check_ys("mid_rst", '0);
    @(negedge clk);
    rst = 1'b0;
    run_frame("post_rst", X_MIX, C_MIX, E_MIX);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
